// File: rtl/lc3_pkg.sv
// Shared LC3 pipeline definitions: opcodes, controller mem_state encoding and
// the memory-access FSM states.
package lc3_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RES  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } op_t;

  localparam logic [2:0] MEM_RD   = 3'd0;
  localparam logic [2:0] MEM_IND  = 3'd1;
  localparam logic [2:0] MEM_WR   = 3'd2;
  localparam logic [2:0] MEM_IDLE = 3'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    IND  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } memacc_state_t;

endpackage

// File: rtl/lc3_memaccess.sv
// LC3 memory-access stage: one load/store/indirect transaction per request over
// a req/ack data-memory port, with a per-access watchdog.
module lc3_memaccess
  import lc3_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_mem_i,
  input  logic [2:0]  mem_state_i,
  input  logic [15:0] ir_exec_i,
  input  logic [15:0] m_addr_i,
  input  logic [15:0] m_data_i,
  input  logic [15:0] dmem_dout_i,
  input  logic        dmem_ack_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [15:0] dmem_addr_o,
  output logic [15:0] dmem_din_o,
  output logic [15:0] memout_o,
  output logic        complete_data_o,
  output logic        mem_err_o
);

  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 32'd1);

  memacc_state_t state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          store_q, store_d;
  logic [15:0]   memout_q, memout_d;
  logic [15:0]   wait_q, wait_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic          complete_q, complete_d;
  logic          err_q, err_d;

  // Only bit 12 of the instruction matters here.
  logic unused_ir_s;
  assign unused_ir_s = ^{ir_exec_i[15:13], ir_exec_i[11:0]};

  // Next-state, latching and watchdog logic; outputs decoded from the next state
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    store_d    = store_q;
    memout_d   = memout_q;
    wait_d     = wait_q;
    complete_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_mem_i) begin
          case (mem_state_i)
            MEM_RD:  state_d = RD;
            MEM_IND: state_d = IND;
            MEM_WR:  state_d = WR;
            default: state_d = IDLE;
          endcase
          if (state_d != IDLE) begin
            addr_d  = m_addr_i;
            data_d  = m_data_i;
            store_d = ir_exec_i[12];
            wait_d  = 16'd0;
          end else begin
            wait_d = wait_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD, IND, WR: begin
        // Ack wins over the watchdog when both land on the same edge.
        if (dmem_ack_i) begin
          if (state_q == IND) begin
            addr_d  = dmem_dout_i;
            state_d = store_q ? WR : RD;
            wait_d  = 16'd0;
          end else if (state_q == RD) begin
            memout_d = dmem_dout_i;
            state_d  = DONE;
          end else begin
            state_d = DONE;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_d      = (state_d == RD) || (state_d == IND) || (state_d == WR);
    we_d       = (state_d == WR);
    complete_d = (state_d == DONE);
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= 16'd0;
      data_q     <= 16'd0;
      store_q    <= 1'b0;
      memout_q   <= 16'd0;
      wait_q     <= 16'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      complete_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      store_q    <= store_d;
      memout_q   <= memout_d;
      wait_q     <= wait_d;
      req_q      <= req_d;
      we_q       <= we_d;
      complete_q <= complete_d;
      err_q      <= err_d;
    end
  end

  assign dmem_req_o      = req_q;
  assign dmem_we_o       = we_q;
  assign dmem_addr_o     = addr_q;
  assign dmem_din_o      = data_q;
  assign memout_o        = memout_q;
  assign complete_data_o = complete_q;
  assign mem_err_o       = err_q;

endmodule

// File: tb/tb_lc3_memaccess.sv
// Self-checking bench for lc3_memaccess: directed scenarios plus random
// transactions compared cycle-by-cycle against a transaction-level timeline model.
module tb_lc3_memaccess;
  import lc3_pkg::*;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_mem;
  logic [2:0]  mem_state;
  logic [15:0] ir_exec;
  logic [15:0] m_addr;
  logic [15:0] m_data;
  logic [15:0] dmem_dout;
  logic        dmem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_din;
  logic [15:0] memout;
  logic        complete_data;
  logic        mem_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lc3_memaccess #(.MAX_WAIT(MAXW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_mem_i   (enable_mem),
    .mem_state_i    (mem_state),
    .ir_exec_i      (ir_exec),
    .m_addr_i       (m_addr),
    .m_data_i       (m_data),
    .dmem_dout_i    (dmem_dout),
    .dmem_ack_i     (dmem_ack),
    .dmem_req_o     (dmem_req),
    .dmem_we_o      (dmem_we),
    .dmem_addr_o    (dmem_addr),
    .dmem_din_o     (dmem_din),
    .memout_o       (memout),
    .complete_data_o(complete_data),
    .mem_err_o      (mem_err)
  );

  // One expected bus cycle, as seen between two rising edges.
  typedef struct {
    logic        req;
    logic        we;
    logic        ack;
    logic        cd;
    logic        err;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic [15:0] mout;
  } cyc_t;

  cyc_t        tl[$];
  logic [15:0] mem [logic [15:0]];
  logic [15:0] memout_exp = 16'h0000;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = 16'($urandom);
    return mem[a];
  endfunction

  // Appends one access to the timeline: w wait cycles, then an ack, or a
  // watchdog expiry after MAXW unacknowledged request cycles.
  task automatic add_access(input logic [15:0] a, input logic we, input logic [15:0] din,
                            input int w, output bit ok, output logic [15:0] rdata);
    cyc_t c;
    rdata = we ? 16'h0000 : mem_rd(a);
    for (int i = 0; i < w && i < MAXW; i++) begin
      c = '{req:1'b1, we:we, ack:1'b0, cd:1'b0, err:1'b0, addr:a, din:din,
            dout:16'($urandom), mout:memout_exp};
      tl.push_back(c);
    end
    ok = (w < MAXW);
    if (ok) begin
      c = '{req:1'b1, we:we, ack:1'b1, cd:1'b0, err:1'b0, addr:a, din:din,
            dout:rdata, mout:memout_exp};
      tl.push_back(c);
    end
  endtask

  task automatic check_cycle(input cyc_t c);
    check("req", {15'h0, dmem_req}, {15'h0, c.req});
    check("complete", {15'h0, complete_data}, {15'h0, c.cd});
    check("mem_err", {15'h0, mem_err}, {15'h0, c.err});
    check("memout", memout, c.mout);
    if (c.req) begin
      check("addr", dmem_addr, c.addr);
      check("we", {15'h0, dmem_we}, {15'h0, c.we});
      if (c.we) check("din", dmem_din, c.din);
    end
  endtask

  task automatic run_txn(input logic [2:0] ms, input logic st, input logic [15:0] a,
                         input logic [15:0] d, input int w1, input int w2, input bit spam);
    bit          ok;
    logic [15:0] r;
    logic [15:0] p;
    cyc_t        c;
    tl.delete();
    if (ms == MEM_RD) begin
      add_access(a, 1'b0, d, w1, ok, r);
      if (ok) memout_exp = r;
    end else if (ms == MEM_IND) begin
      add_access(a, 1'b0, d, w1, ok, p);
      if (ok) begin
        add_access(p, st, d, w2, ok, r);
        if (ok && !st) memout_exp = r;
        if (ok && st) mem[p] = d;
      end
    end else begin
      add_access(a, 1'b1, d, w1, ok, r);
      if (ok) mem[a] = d;
    end
    c = '{req:1'b0, we:1'b0, ack:1'b0, cd:1'b1, err:!ok, addr:16'h0, din:16'h0,
          dout:16'h0, mout:memout_exp};
    tl.push_back(c);
    c.cd  = 1'b0;
    c.err = 1'b0;
    tl.push_back(c);

    @(negedge clk);
    enable_mem = 1'b1;
    mem_state  = ms;
    ir_exec    = {3'($urandom), st, 12'($urandom)};
    m_addr     = a;
    m_data     = d;
    @(negedge clk);
    enable_mem = 1'b0;
    ir_exec    = 16'($urandom);
    m_addr     = 16'($urandom);
    m_data     = 16'($urandom);
    foreach (tl[k]) begin
      check_cycle(tl[k]);
      dmem_ack   = tl[k].ack;
      dmem_dout  = tl[k].dout;
      enable_mem = spam && (k == 1);
      mem_state  = 3'($urandom_range(0, 2));
      @(negedge clk);
    end
    enable_mem = 1'b0;
    dmem_ack   = 1'b0;
  endtask

  task automatic ignore_req(input logic [2:0] ms);
    @(negedge clk);
    enable_mem = 1'b1;
    mem_state  = ms;
    m_addr     = 16'($urandom);
    @(negedge clk);
    enable_mem = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ign_req", {15'h0, dmem_req}, 16'h0000);
      check("ign_cd", {15'h0, complete_data}, 16'h0000);
      @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b1;
    enable_mem = 1'b0;
    mem_state  = MEM_IDLE;
    ir_exec    = 16'h0000;
    m_addr     = 16'h0000;
    m_data     = 16'h0000;
    dmem_dout  = 16'h0000;
    dmem_ack   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", {15'h0, dmem_req}, 16'h0000);
    check("rst_we", {15'h0, dmem_we}, 16'h0000);
    check("rst_addr", dmem_addr, 16'h0000);
    check("rst_din", dmem_din, 16'h0000);
    check("rst_memout", memout, 16'h0000);
    check("rst_cd", {15'h0, complete_data}, 16'h0000);
    check("rst_err", {15'h0, mem_err}, 16'h0000);
    rst = 1'b0;

    mem[16'h3000] = 16'hBEEF;
    run_txn(MEM_RD, 1'b0, 16'h3000, 16'h0000, 0, 0, 1'b0);
    mem[16'h3010] = 16'h4000;
    run_txn(MEM_IND, 1'b1, 16'h3010, 16'h1234, 2, 2, 1'b0);
    check("sti_mem", mem[16'h4000], 16'h1234);
    mem[16'h3020] = 16'h5000;
    mem[16'h5000] = 16'h00FF;
    run_txn(MEM_IND, 1'b0, 16'h3020, 16'h0000, 0, 0, 1'b0);
    run_txn(MEM_RD, 1'b0, 16'h3040, 16'h0000, MAXW + 3, 0, 1'b0);
    run_txn(MEM_RD, 1'b0, 16'h3044, 16'h0000, MAXW - 1, 0, 1'b0);
    run_txn(MEM_IND, 1'b0, 16'h3048, 16'h0000, 1, MAXW, 1'b0);
    ignore_req(MEM_IDLE);
    ignore_req(3'd6);
    run_txn(MEM_WR, 1'b0, 16'h3050, 16'hABCD, 3, 0, 1'b1);

    // Reset while the second access of an indirect load is waiting.
    @(negedge clk);
    enable_mem = 1'b1;
    mem_state  = MEM_IND;
    ir_exec    = 16'hA000;
    m_addr     = 16'h3060;
    @(negedge clk);
    enable_mem = 1'b0;
    check("rsti_req1", {15'h0, dmem_req}, 16'h0001);
    dmem_ack   = 1'b1;
    dmem_dout  = 16'h6000;
    @(negedge clk);
    dmem_ack   = 1'b0;
    check("rsti_req2", {15'h0, dmem_req}, 16'h0001);
    check("rsti_addr2", dmem_addr, 16'h6000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    memout_exp = 16'h0000;
    check("rsti_req", {15'h0, dmem_req}, 16'h0000);
    check("rsti_addr", dmem_addr, 16'h0000);
    check("rsti_memout", memout, 16'h0000);
    check("rsti_cd", {15'h0, complete_data}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rsti_nocd", {15'h0, complete_data}, 16'h0000);
    end
    run_txn(MEM_RD, 1'b0, 16'h3000, 16'h0000, 1, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_txn(3'($urandom_range(0, 2)), 1'($urandom), {8'h30, 4'h0, 4'($urandom)},
              16'($urandom), $urandom_range(0, MAXW), $urandom_range(0, MAXW),
              1'($urandom));
      if (($urandom % 8) == 0) ignore_req(3'($urandom_range(3, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
